// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point adder: default format,
// field helpers and the result classification used by the normalise stage.
package fp_pkg;

    localparam int EXP_W_DEF = 5;
    localparam int MAN_W_DEF = 10;
    localparam int FP_W_DEF  = 1 + EXP_W_DEF + MAN_W_DEF;

    typedef struct packed {
        logic                 sign;
        logic [EXP_W_DEF-1:0] exp;
        logic [MAN_W_DEF-1:0] frac;
    } fp_fields_t;

    typedef enum logic [2:0] {
        RES_NORMAL  = 3'd0,
        RES_ZERO    = 3'd1,
        RES_UNF     = 3'd2,
        RES_OVF     = 3'd3,
        RES_SPECIAL = 3'd4
    } res_class_t;

    function automatic int fp_sign_pos(input int exp_w, input int man_w);
        return exp_w + man_w;
    endfunction

    function automatic int fp_exp_lsb(input int man_w);
        return man_w;
    endfunction

    function automatic int fp_bias(input int exp_w);
        return (32'sd1 <<< (exp_w - 32'sd1)) - 32'sd1;
    endfunction

    function automatic fp_fields_t fp_unpack(input logic [FP_W_DEF-1:0] word);
        return fp_fields_t'(word);
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
    parameter int W  = 15,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    // Scan upward so the highest set bit determines the final count.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count = CW'(W - 1 - i);
            end else begin
                count = count;
            end
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// 3-stage pipelined FP adder/subtractor (align, add, normalise/round) with
// valid/ready flow control. Define FP_ADD_PIPE_RNE_EN for round-to-nearest-even; default truncates.
module fp_add_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_res,
    output logic                 out_ovf,
    output logic                 out_unf,
    output logic                 out_zero
);

    localparam int FW = 1 + EXP_W + MAN_W;
    localparam int AW = EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;
    localparam int SW = MAN_W + 5;
    localparam int XW = EXP_W + 2;
    localparam int CW = $clog2(SW + 1);

    localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ZERO  = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0] MAX_SHIFT = EXP_W'(MAN_W + 2);
    localparam logic [XW-1:0]    X_ONE     = {{(XW-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fields_t;

    logic adv_s;

    fields_t          a_s, b_s;
    logic             b_eff_sign_s;
    logic [AW-1:0]    a_mag_s, b_mag_s, big_mag_s, small_mag_s;
    logic             big_sign_s, small_sign_s, small_nz_s;
    logic [MW-1:0]    big_man_s, small_man_s, small_al_s, lost_s;
    logic [EXP_W-1:0] exp_diff_s;
    logic             special_s;
    logic [FW-1:0]    special_res_s;

    logic             s1_valid_r, s1_big_sign_r, s1_small_sign_r, s1_special_r;
    logic [EXP_W-1:0] s1_exp_r;
    logic [MW-1:0]    s1_big_man_r, s1_small_man_r;
    logic [FW-1:0]    s1_special_res_r;

    logic             eff_sub_s;
    logic [SW-1:0]    sum_s;

    logic             s2_valid_r, s2_sign_r, s2_special_r;
    logic [EXP_W-1:0] s2_exp_r;
    logic [SW-1:0]    s2_sum_r;
    logic [FW-1:0]    s2_special_res_r;

    logic [CW-1:0]    lzc_s;
    logic [SW-1:0]    shifted_s;
    logic [XW-1:0]    exp_n_s, exp_f_s;
    logic             hid_s;
    logic [MAN_W-1:0] frac_s;
    res_class_t       cls_s;
    logic [FW-1:0]    res_s;
    logic             ovf_s, unf_s, zero_s;

    logic             out_valid_r, out_ovf_r, out_unf_r, out_zero_r;
    logic [FW-1:0]    out_res_r;

    assign adv_s     = out_ready | ~out_valid_r;
    assign in_ready  = adv_s;
    assign out_valid = out_valid_r;
    assign out_res   = out_res_r;
    assign out_ovf   = out_ovf_r;
    assign out_unf   = out_unf_r;
    assign out_zero  = out_zero_r;

    // Align: order operands by magnitude and shift the smaller mantissa with sticky collection.
    always_comb begin
        a_s          = in_a;
        b_s          = in_b;
        b_eff_sign_s = b_s.sign ^ in_sub;
        a_mag_s      = (a_s.exp == EXP_ZERO) ? {AW{1'b0}} : {a_s.exp, a_s.frac};
        b_mag_s      = (b_s.exp == EXP_ZERO) ? {AW{1'b0}} : {b_s.exp, b_s.frac};
        if (a_mag_s >= b_mag_s) begin
            big_mag_s    = a_mag_s;
            small_mag_s  = b_mag_s;
            big_sign_s   = a_s.sign;
            small_sign_s = b_eff_sign_s;
        end else begin
            big_mag_s    = b_mag_s;
            small_mag_s  = a_mag_s;
            big_sign_s   = b_eff_sign_s;
            small_sign_s = a_s.sign;
        end
        big_man_s   = {big_mag_s[AW-1:MAN_W] != EXP_ZERO, big_mag_s[MAN_W-1:0], 3'b000};
        small_man_s = {small_mag_s[AW-1:MAN_W] != EXP_ZERO, small_mag_s[MAN_W-1:0], 3'b000};
        exp_diff_s  = big_mag_s[AW-1:MAN_W] - small_mag_s[AW-1:MAN_W];
        small_nz_s  = (small_mag_s != {AW{1'b0}});
        lost_s      = {MW{1'b0}};
        if (exp_diff_s > MAX_SHIFT) begin
            small_al_s = {{(MW-1){1'b0}}, small_nz_s};
        end else begin
            lost_s     = small_man_s & ~({MW{1'b1}} << exp_diff_s);
            small_al_s = (small_man_s >> exp_diff_s) | {{(MW-1){1'b0}}, (lost_s != {MW{1'b0}})};
        end
        special_s     = (a_s.exp == EXP_ONES) | (b_s.exp == EXP_ONES);
        special_res_s = (a_s.exp == EXP_ONES) ? in_a : in_b;
    end

    // Stage 1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r       <= 1'b0;
            s1_big_sign_r    <= 1'b0;
            s1_small_sign_r  <= 1'b0;
            s1_special_r     <= 1'b0;
            s1_exp_r         <= {EXP_W{1'b0}};
            s1_big_man_r     <= {MW{1'b0}};
            s1_small_man_r   <= {MW{1'b0}};
            s1_special_res_r <= {FW{1'b0}};
        end else if (adv_s) begin
            s1_valid_r       <= in_valid;
            s1_big_sign_r    <= big_sign_s;
            s1_small_sign_r  <= small_sign_s;
            s1_special_r     <= special_s;
            s1_exp_r         <= big_mag_s[AW-1:MAN_W];
            s1_big_man_r     <= big_man_s;
            s1_small_man_r   <= small_al_s;
            s1_special_res_r <= special_res_s;
        end
    end

    // Add: magnitudes are ordered, so subtraction never goes negative.
    always_comb begin
        eff_sub_s = s1_big_sign_r ^ s1_small_sign_r;
        if (eff_sub_s) begin
            sum_s = {1'b0, s1_big_man_r} - {1'b0, s1_small_man_r};
        end else begin
            sum_s = {1'b0, s1_big_man_r} + {1'b0, s1_small_man_r};
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r       <= 1'b0;
            s2_sign_r        <= 1'b0;
            s2_special_r     <= 1'b0;
            s2_exp_r         <= {EXP_W{1'b0}};
            s2_sum_r         <= {SW{1'b0}};
            s2_special_res_r <= {FW{1'b0}};
        end else if (adv_s) begin
            s2_valid_r       <= s1_valid_r;
            s2_sign_r        <= s1_big_sign_r;
            s2_special_r     <= s1_special_r;
            s2_exp_r         <= s1_exp_r;
            s2_sum_r         <= sum_s;
            s2_special_res_r <= s1_special_res_r;
        end
    end

    fp_lzc #(.W(SW), .CW(CW)) u_lzc (
        .value (s2_sum_r),
        .count (lzc_s)
    );

    // Shifting by the full lzc covers both the carry-out and cancellation cases in one step.
    assign shifted_s = s2_sum_r << lzc_s;
    assign exp_n_s   = {2'b00, s2_exp_r} + X_ONE - XW'(lzc_s);

`ifdef FP_ADD_PIPE_RNE_EN
    logic [MW-1:0] norm_s;
    logic          round_up_s, rnd_carry_s;

    // Round to nearest even; a carry out of the fraction bumps the exponent.
    always_comb begin
        norm_s                = {shifted_s[SW-1:2], shifted_s[1] | shifted_s[0]};
        hid_s                 = norm_s[MW-1];
        round_up_s            = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        {rnd_carry_s, frac_s} = {1'b0, norm_s[MW-2:3]} + {{MAN_W{1'b0}}, round_up_s};
        exp_f_s               = exp_n_s + {{(XW-1){1'b0}}, rnd_carry_s};
    end
`else
    logic [MAN_W:0] trunc_s;

    // Truncate: keep the hidden bit and fraction, drop guard/round/sticky.
    always_comb begin
        trunc_s = (MAN_W + 1)'(shifted_s >> (SW - MAN_W - 1));
        hid_s   = trunc_s[MAN_W];
        frac_s  = trunc_s[MAN_W-1:0];
        exp_f_s = exp_n_s;
    end
`endif

    // Classify and build the final result and flags.
    always_comb begin
        if (s2_special_r) begin
            cls_s = RES_SPECIAL;
        end else if (!hid_s) begin
            cls_s = RES_ZERO;
        end else if (exp_n_s[XW-1] || (exp_n_s == {XW{1'b0}})) begin
            cls_s = RES_UNF;
        end else if (exp_f_s >= {2'b00, EXP_ONES}) begin
            cls_s = RES_OVF;
        end else begin
            cls_s = RES_NORMAL;
        end
        res_s  = {FW{1'b0}};
        ovf_s  = 1'b0;
        unf_s  = 1'b0;
        zero_s = 1'b0;
        case (cls_s)
            RES_SPECIAL: begin
                res_s = s2_special_res_r;
                ovf_s = 1'b1;
            end
            RES_ZERO: begin
                zero_s = 1'b1;
            end
            RES_UNF: begin
                res_s  = {s2_sign_r, {AW{1'b0}}};
                unf_s  = 1'b1;
                zero_s = 1'b1;
            end
            RES_OVF: begin
                res_s = {s2_sign_r, EXP_ONES, {MAN_W{1'b0}}};
                ovf_s = 1'b1;
            end
            RES_NORMAL: begin
                res_s = {s2_sign_r, exp_f_s[EXP_W-1:0], frac_s};
            end
            default: begin
                res_s = {FW{1'b0}};
            end
        endcase
    end

    // Output register; result and flags hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_res_r   <= {FW{1'b0}};
            out_ovf_r   <= 1'b0;
            out_unf_r   <= 1'b0;
            out_zero_r  <= 1'b0;
        end else if (adv_s) begin
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                out_res_r  <= res_s;
                out_ovf_r  <= ovf_s;
                out_unf_r  <= unf_s;
                out_zero_r <= zero_s;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed self-checking bench for fp_add_pipe in the default half-precision format.
module tb_fp_add_pipe;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_sub, out_valid, out_ready;
    logic [15:0] in_a, in_b, out_res;
    logic        out_ovf, out_unf, out_zero;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] res;
        logic [2:0]  flg;
    } vec_t;

    vec_t vq[$];

`ifdef FP_ADD_PIPE_RNE_EN
    localparam logic [15:0] TIE_RES   = 16'h3C02;
    localparam logic [15:0] CARRY_RES = 16'h4000;
`else
    localparam logic [15:0] TIE_RES   = 16'h3C01;
    localparam logic [15:0] CARRY_RES = 16'h3FFF;
`endif

    fp_add_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic add_vec(input logic [15:0] a, input logic [15:0] b, input logic sub,
                           input logic [15:0] res, input logic [2:0] flg);
        vec_t v;
        v.a = a; v.b = b; v.sub = sub; v.res = res; v.flg = flg;
        vq.push_back(v);
    endtask

    // Streams every queued vector, stalling out_ready for stall_len cycles from stall_start.
    task automatic run_queue(input string tag, input int stall_start, input int stall_len);
        int sent = 0;
        int got  = 0;
        int n    = vq.size();
        for (int cyc = 0; cyc < 300 && got < n; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
            if (sent < n) begin
                in_valid = 1'b1;
                in_a     = vq[sent].a;
                in_b     = vq[sent].b;
                in_sub   = vq[sent].sub;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready && out_valid) begin
                check($sformatf("%s_hold%0d", tag, cyc), {16'h0, out_res}, {16'h0, vq[got].res});
                check($sformatf("%s_full%0d", tag, cyc), {31'h0, in_ready}, 32'h0);
            end
            if (out_valid && out_ready) begin
                check($sformatf("%s_res%0d", tag, got), {16'h0, out_res}, {16'h0, vq[got].res});
                check($sformatf("%s_flg%0d", tag, got), {29'h0, out_ovf, out_unf, out_zero},
                      {29'h0, vq[got].flg});
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_count"}, got, n);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 check({tag, "_idle"}, {31'h0, out_valid}, 32'h0);
        end
        vq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_res",   {16'h0, out_res}, 32'h0);
        check("rst_flags", {29'h0, out_ovf, out_unf, out_zero}, 32'h0);
        check("rst_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk) rst_n = 1'b1;

        // Latency of a single operation with no stall.
        @(negedge clk);
        in_a = 16'h3C00; in_b = 16'h4000; in_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1 check("lat_in_ready", {31'h0, in_ready}, 32'h1);
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            lat++;
            #1 in_valid = 1'b0;
            if (out_valid) break;
        end
        check("lat_cycles", lat, 3);
        check("lat_res",    {16'h0, out_res}, 32'h4200);
        check("lat_flags",  {29'h0, out_ovf, out_unf, out_zero}, 32'h0);
        repeat (2) @(negedge clk);

        // Directed arithmetic vectors, flags are {ovf, unf, zero}.
        add_vec(16'h3C00, 16'h4000, 1'b0, 16'h4200, 3'b000);
        add_vec(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b001);
        add_vec(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b100);
        add_vec(16'hFBFF, 16'hFBFF, 1'b0, 16'hFC00, 3'b100);
        add_vec(16'h3C01, 16'h1000, 1'b0, TIE_RES,  3'b000);
        add_vec(16'h3FFF, 16'h1000, 1'b0, CARRY_RES, 3'b000);
        add_vec(16'h3C00, 16'h4000, 1'b1, 16'hBC00, 3'b000);
        add_vec(16'h0401, 16'h0400, 1'b1, 16'h0000, 3'b011);
        add_vec(16'h8401, 16'h8400, 1'b1, 16'h8000, 3'b011);
        add_vec(16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 3'b100);
        add_vec(16'h3C00, 16'hFC00, 1'b0, 16'hFC00, 3'b100);
        add_vec(16'h7E00, 16'hFC00, 1'b0, 16'h7E00, 3'b100);
        add_vec(16'h3C00, 16'h0001, 1'b0, 16'h3C00, 3'b000);
        add_vec(16'h3C00, 16'h0400, 1'b0, 16'h3C00, 3'b000);
        add_vec(16'h3C00, 16'hBC00, 1'b0, 16'h0000, 3'b001);
        run_queue("vec", 1000, 0);

        // Back-pressure: four ops with the consumer stalled for five cycles.
        add_vec(16'h3C00, 16'h4000, 1'b0, 16'h4200, 3'b000);
        add_vec(16'h3C00, 16'h4000, 1'b1, 16'hBC00, 3'b000);
        add_vec(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b100);
        add_vec(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b001);
        run_queue("stall", 2, 5);

        // Reset with operations in flight.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h4000; in_sub = 1'b0;
        @(negedge clk);
        in_a = 16'h7BFF; in_b = 16'h7BFF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 check("rst_pre_valid", {31'h0, out_valid}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'h0, out_valid}, 32'h0);
        check("rst_mid_res",   {16'h0, out_res}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1 check("rst_no_stale", {31'h0, out_valid}, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
